// File: rtl/bram_dp_clr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bram_dp_clr : true dual-port BRAM with clear sweep, collision detection.   |
// | Optional: BRAM_OUTREG_EN adds an output pipeline register (2-cycle read).  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module bram_dp_clr #(
    parameter int                    DATA_WIDTH  = 16,
    parameter int                    ADDR_WIDTH  = 10,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0,
    parameter int                    PRIORITY_A  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    output logic                  busy,
    input  logic                  en_a,
    input  logic                  we_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] data_a,
    output logic [DATA_WIDTH-1:0] q_a,
    input  logic                  en_b,
    input  logic                  we_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] data_b,
    output logic [DATA_WIDTH-1:0] q_b,
    output logic                  collision
);

    localparam int DEPTH = 2**ADDR_WIDTH;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_cnt, w_cnt_nxt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_q_a, r_q_b;
    logic                  r_coll;
    logic                  w_run, w_acc_a, w_acc_b, w_wr_a, w_wr_b, w_coll;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_CLEAR: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (&r_cnt)
                    w_state_nxt = ST_IDLE;
            end
            default: begin
                if (clear) begin
                    w_state_nxt = ST_CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
        endcase
    end

    // A clear request in IDLE wins over any port access in the same cycle.
    assign w_run   = (r_state == ST_IDLE) && !clear;
    assign w_acc_a = w_run && en_a;
    assign w_acc_b = w_run && en_b;
    assign w_wr_a  = w_acc_a && we_a;
    assign w_wr_b  = w_acc_b && we_b;
    assign w_coll  = w_wr_a && w_wr_b && (addr_a == addr_b);

    // Array is never reset; the sweep only starts on the first edge out of reset.
    always_ff @(posedge clk) begin
        if (r_state == ST_CLEAR) begin
            if (rst_n)
                mem[r_cnt] <= CLEAR_VALUE;
        end else if (w_coll) begin
            mem[addr_a] <= (PRIORITY_A != 0) ? data_a : data_b;
        end else begin
            if (w_wr_a)
                mem[addr_a] <= data_a;
            if (w_wr_b)
                mem[addr_b] <= data_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q_a  <= '0;
            r_q_b  <= '0;
            r_coll <= 1'b0;
        end else begin
            r_coll <= w_coll;
            if (!w_run) begin
                r_q_a <= '0;
                r_q_b <= '0;
            end else begin
                // Write-first on own port; the other port reads old contents.
                if (w_acc_a)
                    r_q_a <= we_a ? data_a : mem[addr_a];
                if (w_acc_b)
                    r_q_b <= we_b ? data_b : mem[addr_b];
            end
        end
    end

`ifdef BRAM_OUTREG_EN
    logic [DATA_WIDTH-1:0] r_q_a_pipe, r_q_b_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q_a_pipe <= '0;
            r_q_b_pipe <= '0;
        end else begin
            r_q_a_pipe <= r_q_a;
            r_q_b_pipe <= r_q_b;
        end
    end

    assign q_a = r_q_a_pipe;
    assign q_b = r_q_b_pipe;
`else
    assign q_a = r_q_a;
    assign q_b = r_q_b;
`endif

    assign busy      = (r_state == ST_CLEAR);
    assign collision = r_coll;

endmodule
`default_nettype wire

// File: tb/tb_bram_dp_clr.sv
`default_nettype none
// Scoreboard bench for bram_dp_clr: stimulus queues expected read data, a
// monitor pops and compares when the read latency has elapsed.
module tb_bram_dp_clr;

    localparam int DW = 16;
    localparam int AW = 10;
`ifdef BRAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n, clear;
    logic          en_a, we_a, en_b, we_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] data_a, data_b;
    logic          busy, collision, busy2, collision2;
    logic [DW-1:0] q_a, q_b, q_a2, q_b2;

    bram_dp_clr #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLEAR_VALUE(16'h0000), .PRIORITY_A(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .busy(busy),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .data_a(data_a), .q_a(q_a),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .data_b(data_b), .q_b(q_b),
        .collision(collision)
    );

    bram_dp_clr #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLEAR_VALUE(16'h0000), .PRIORITY_A(0)) u_dut_p0 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .busy(busy2),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .data_a(data_a), .q_a(q_a2),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .data_b(data_b), .q_b(q_b2),
        .collision(collision2)
    );

    always #5 clk = ~clk;

    int            n_chk  = 0;
    int            n_fail = 0;
    logic [DW-1:0] exp_qa[$];
    logic [DW-1:0] exp_qb[$];
    logic          chk_a = 1'b0;
    logic          chk_b = 1'b0;
    logic [1:0]    pipe_a, pipe_b;
    logic [DW-1:0] e_a, e_b;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_a <= '0;
            pipe_b <= '0;
        end else begin
            pipe_a <= {pipe_a[0], chk_a};
            pipe_b <= {pipe_b[0], chk_b};
        end
    end

    always @(negedge clk) begin
        if (pipe_a[LAT-1]) begin
            n_chk++;
            if (exp_qa.size() == 0) begin
                n_fail++;
                $display("FAIL q_a: output with empty scoreboard, actual %h", q_a);
            end else begin
                e_a = exp_qa.pop_front();
                if (q_a !== e_a) begin
                    n_fail++;
                    $display("FAIL q_a @%0t: actual %h required %h", $time, q_a, e_a);
                end
            end
        end
        if (pipe_b[LAT-1]) begin
            n_chk++;
            if (exp_qb.size() == 0) begin
                n_fail++;
                $display("FAIL q_b: output with empty scoreboard, actual %h", q_b);
            end else begin
                e_b = exp_qb.pop_front();
                if (q_b !== e_b) begin
                    n_fail++;
                    $display("FAIL q_b @%0t: actual %h required %h", $time, q_b, e_b);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: actual %0h required %0h", name, $time, act, exp);
        end
    endtask

    task automatic cyc(input logic ea, input logic wa, input int aa, input logic [DW-1:0] da,
                       input logic ca, input logic [DW-1:0] xa,
                       input logic eb, input logic wb, input int ab, input logic [DW-1:0] db,
                       input logic cb, input logic [DW-1:0] xb);
        en_a = ea; we_a = wa; addr_a = aa[AW-1:0]; data_a = da; chk_a = ca;
        en_b = eb; we_b = wb; addr_b = ab[AW-1:0]; data_b = db; chk_b = cb;
        if (ca) exp_qa.push_back(xa);
        if (cb) exp_qb.push_back(xb);
        @(negedge clk);
        en_a = 1'b0; we_a = 1'b0; en_b = 1'b0; we_b = 1'b0;
        chk_a = 1'b0; chk_b = 1'b0;
    endtask

    // Counts cycles busy stays high; optionally attempts writes meanwhile.
    task automatic sweep_len(input logic poke);
        int cnt;
        cnt = 0;
        while (busy && cnt < 3000) begin
            if (poke && cnt < 64) begin
                en_a = 1'b1; we_a = 1'b1; addr_a = cnt[AW-1:0];        data_a = 16'hFFFF;
                en_b = 1'b1; we_b = 1'b1; addr_b = AW'(cnt + 64);      data_b = 16'hEEEE;
            end else begin
                en_a = 1'b0; we_a = 1'b0; en_b = 1'b0; we_b = 1'b0;
            end
            @(negedge clk);
            cnt++;
        end
        en_a = 1'b0; we_a = 1'b0; en_b = 1'b0; we_b = 1'b0;
        check("sweep_cycles", cnt, 1024);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; clear = 1'b0;
        en_a = 1'b0; we_a = 1'b0; addr_a = '0; data_a = '0;
        en_b = 1'b0; we_b = 1'b0; addr_b = '0; data_b = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 1);
        check("reset_q_a", q_a, 0);
        check("reset_q_b", q_b, 0);
        check("reset_collision", collision, 0);
        rst_n = 1'b1;
        sweep_len(1'b0);

        for (int i = 0; i < 1024; i++)
            cyc(1, 0, i, 16'h0, 1, 16'h0, 1, 0, i, 16'h0, 1, 16'h0);

        // Cross-port read-during-write: B sees old contents.
        cyc(1, 1, 7, 16'h1234, 1, 16'h1234, 1, 0, 7, 16'h0, 1, 16'h0000);
        cyc(0, 0, 0, 16'h0, 0, 16'h0, 1, 0, 7, 16'h0, 1, 16'h1234);

        // Same-address double write.
        cyc(1, 1, 5, 16'hAAAA, 1, 16'hAAAA, 1, 1, 5, 16'h5555, 1, 16'h5555);
        check("collision_set", collision, 1);
        check("collision_set_p0", collision2, 1);
        @(negedge clk);
        check("collision_clear", collision, 0);
        cyc(1, 0, 5, 16'h0, 1, 16'hAAAA, 0, 0, 0, 16'h0, 0, 16'h0);
        @(negedge clk);
        check("readback_p0", q_a2, 16'h5555);

        cyc(1, 1, 8, 16'h1111, 1, 16'h1111, 1, 1, 9, 16'h2222, 1, 16'h2222);
        check("no_collision_diff_addr", collision, 0);
        cyc(1, 1, 10, 16'h3333, 1, 16'h3333, 1, 0, 10, 16'h0, 1, 16'h0000);
        check("no_collision_single_write", collision, 0);

        for (int i = 0; i < 32; i++)
            cyc(1, 1, i, 16'(i), 1, 16'(i), 0, 0, 0, 16'h0, 0, 16'h0);
        for (int i = 0; i < 32; i++)
            cyc(0, 0, 0, 16'h0, 0, 16'h0, 1, 0, i, 16'h0, 1, 16'(i));
        repeat (2) @(negedge clk);
        check("q_b_hold", q_b, 31);

        // Clear request with a simultaneous write that must be dropped.
        clear = 1'b1; en_a = 1'b1; we_a = 1'b1; addr_a = 10'd3; data_a = 16'hBEEF;
        @(negedge clk);
        clear = 1'b0; en_a = 1'b0; we_a = 1'b0;
        check("clear_busy", busy, 1);
        check("clear_q_a", q_a, 0);
        check("clear_q_b", q_b, 0);
        sweep_len(1'b1);
        for (int i = 0; i < 64; i++)
            cyc(1, 0, i, 16'h0, 1, 16'h0, 1, 0, i + 64, 16'h0, 1, 16'h0);

        // Reset in the middle of an access.
        cyc(1, 1, 5, 16'hAAAA, 1, 16'hAAAA, 1, 1, 5, 16'h5555, 1, 16'h5555);
        check("collision_before_reset", collision, 1);
        #1;
        rst_n = 1'b0;
        exp_qa.delete();
        exp_qb.delete();
        #1;
        check("async_reset_collision", collision, 0);
        check("async_reset_q_a", q_a, 0);
        check("async_reset_q_b", q_b, 0);
        check("async_reset_busy", busy, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset at sweep cycle 100.
        repeat (100) @(negedge clk);
        check("mid_sweep_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_sweep_reset_q_a", q_a, 0);
        check("mid_sweep_reset_collision", collision, 0);
        @(negedge clk);
        rst_n = 1'b1;
        sweep_len(1'b0);
        cyc(1, 0, 5, 16'h0, 1, 16'h0, 1, 0, 1000, 16'h0, 1, 16'h0);
        repeat (2) @(negedge clk);
        check("p0_after_sweep", q_a2, 0);
        check("scoreboard_drained", exp_qa.size() + exp_qb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bram_dp_clr.md
# bram_dp_clr

Parametrised true dual-port block RAM with a built-in memory-clear sequencer, same-address write collision detection and defined read-during-write behaviour. It is the next generation of the project's fixed 16-bit × 1024 dual-port BRAM and is a drop-in memory for the CPU datapath (port A) and the I/O or debug path (port B). After every reset, or on request, it sweeps the whole array to a known value so that software never reads uninitialised contents.

## Interface
- DATA_WIDTH, 16, word width in bits
- ADDR_WIDTH, 10, address width; DEPTH = 2**ADDR_WIDTH words
- CLEAR_VALUE, 0, word written to every location by the clear sweep
- PRIORITY_A, 1, 1 = port A data wins a same-address double write; 0 = port B wins

Ports:
- clk  in  1  single clock, all activity on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- clear  in  1  request a full-array clear sweep (sampled in IDLE only)
- busy  out  1  high while the clear sweep runs; port accesses dropped
- en_a  in  1  port A access enable
- we_a  in  1  port A write enable (qualified by en_a)
- addr_a  in  ADDR_WIDTH  port A address
- data_a  in  DATA_WIDTH  port A write data
- q_a  out  DATA_WIDTH  port A read data
- en_b, we_b, addr_b, data_b, q_b: same as port A, for port B
- collision  out  1  one-cycle pulse on a same-address double write

## Operation
- States: CLEAR, IDLE.
- Reset (rst_n low, asynchronous): state = CLEAR, sweep counter = 0, busy = 1, q_a = q_b = 0, collision = 0. The array itself is not reset.
- CLEAR: each cycle writes CLEAR_VALUE to mem[counter], then counter+1. After the write to DEPTH-1, the block goes to IDLE. All port reads and writes are ignored. q_a/q_b hold 0 and collision stays 0.
- IDLE: clear = 1 → CLEAR with counter = 0. Port accesses in that same cycle are dropped, because clear has priority. While busy, clear is ignored.
- Read (en=1, we=0): q ← mem[addr].
- Write (en=1, we=1): mem[addr] ← data. The same-port output is write-first, so q ← data.
- en=0: no access, and q holds its value.
- Cross-port read-during-write, same address: the reading port sees the old contents (read-first).
- Both ports write the same address in the same cycle:
  - the array stores data_a if PRIORITY_A=1, otherwise data_b;
  - each q shows its own port's data;
  - collision = 1 for exactly one cycle.
- Different addresses, or only one port writing: collision = 0.
- Addresses are always in range (full width, no wrap logic needed).

## Timing
- Read latency: 1 cycle. Address is presented before edge N and q is valid after edge N.
- Clear sweep: exactly DEPTH cycles.
  - busy rises on the edge that samples clear (or asynchronously on reset).
  - busy falls on the edge that writes DEPTH-1.
  - The first port access is accepted on the next edge.
- collision is registered. It asserts after the edge that performs the double write and clears one edge later unless the double write repeats.
- Reset asserted mid-sweep or mid-access: outputs go to their reset values immediately. After release the sweep restarts from 0 and runs a full DEPTH cycles.
- rst_n release is synchronised by the system. The first CLEAR write occurs on the first edge with rst_n high.

## Configuration
- BRAM_OUTREG_EN defined: adds one pipeline register after each q.
  - Read latency becomes 2 cycles. The pipeline register always clocks and is reset to 0.
  - q_a/q_b hold 0 through CLEAR plus one cycle.
  - busy and collision timing are unchanged.
- BRAM_OUTREG_EN undefined: 1-cycle read latency as above (better timing margin is traded for latency).

## Test plan
- Reset, then idle → busy high for exactly 1024 cycles. Then read addr 0..1023 on both ports → every q_a/q_b = CLEAR_VALUE (0).
- Port A writes data=i to addr=i for i=0..31, then port B reads addr 0..31 → q_b = i, 1 cycle after the address (2 with BRAM_OUTREG_EN).
- Same edge: A writes 0x1234 to addr 7 while B reads addr 7 (previously 0) → q_a = 0x1234 and q_b = 0x0000. The next B read of addr 7 → 0x1234.
- Same edge: A writes 0xAAAA and B writes 0x5555 to addr 5 → collision high for exactly one cycle, and a readback of addr 5 gives 0xAAAA. Repeat with PRIORITY_A=0 → 0x5555.
- Fill addr 0..31, pulse clear, and attempt writes while busy → busy high 1024 cycles, all writes dropped, all reads return 0.
- Drive rst_n low at sweep cycle 100 → q_a, q_b and collision read 0 at once. After release, busy stays high a full 1024 cycles.
